mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 39 +++
 rtl/mem_lane_align.sv | 45 ++++
 rtl/mem_responder.sv | 177 +++++++++++++++++
 tb/tb_mem_responder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and ISA load/store funct3 encodings for the memory responder.
package mem_responder_pkg;

  localparam int FUNCT3_W = 3;

  localparam logic [FUNCT3_W-1:0] F3_B  = 3'b000;
  localparam logic [FUNCT3_W-1:0] F3_H  = 3'b001;
  localparam logic [FUNCT3_W-1:0] F3_W  = 3'b010;
  localparam logic [FUNCT3_W-1:0] F3_BU = 3'b100;
  localparam logic [FUNCT3_W-1:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  // Encodings with no defined width fall back to a full word access.
  function automatic size_e access_size(input logic [FUNCT3_W-1:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_BYTE;
      F3_H, F3_HU: return SZ_HALF;
      F3_W:        return SZ_WORD;
      default:     return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_unsigned(input logic [FUNCT3_W-1:0] f3);
    return (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store data/enables shifted into lanes, load data
// shifted down and sign/zero extended.
module mem_lane_align
  import mem_responder_pkg::*;
(
  input  logic [FUNCT3_W-1:0] st_funct3,
  input  logic [1:0]          st_off,
  input  logic [31:0]         st_wdata,
  input  logic [FUNCT3_W-1:0] ld_funct3,
  input  logic [1:0]          ld_off,
  input  logic [31:0]         ld_raw,
  output logic [3:0]          st_be,
  output logic [31:0]         st_lane,
  output logic [31:0]         ld_ext
);

  logic [31:0] ld_shift;
  logic        ld_uns;

  // Store path: move low-aligned data and enables up to the addressed lanes.
  always_comb begin
    st_lane = st_wdata << {st_off, 3'b000};
    case (access_size(st_funct3))
      SZ_BYTE: st_be = 4'b0001 << st_off;
      SZ_HALF: st_be = 4'b0011 << st_off;
      SZ_WORD: st_be = 4'b1111;
      default: st_be = 4'b1111;
    endcase
  end

  // Load path: bring the addressed lanes down to bit 0 and extend.
  always_comb begin
    ld_shift = ld_raw >> {ld_off, 3'b000};
    ld_uns   = is_unsigned(ld_funct3);
    case (access_size(ld_funct3))
      SZ_BYTE: ld_ext = ld_uns ? {24'h000000, ld_shift[7:0]}
                               : {{24{ld_shift[7]}}, ld_shift[7:0]};
      SZ_HALF: ld_ext = ld_uns ? {16'h0000, ld_shift[15:0]}
                               : {{16{ld_shift[15]}}, ld_shift[15:0]};
      SZ_WORD: ld_ext = ld_shift;
      default: ld_ext = ld_shift;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Multi-cycle load/store responder in front of a synchronous-read word RAM.
// Define MEM_RESPONDER_ALIGN_CHECK_EN to fault misaligned accesses instead of masking them.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int RAM_AWIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [FUNCT3_W-1:0]   funct3,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  mem_complete,
  output logic                  mem_fault,
  output logic [RAM_AWIDTH-1:0] ram_addr,
  output logic [3:0]            ram_be,
  output logic [31:0]           ram_wdata,
  output logic                  ram_we,
  input  logic [31:0]           ram_rdata
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_e                state_r, state_s;
  logic [3:0]            cnt_r;
  logic [FUNCT3_W-1:0]   funct3_r;
  logic [1:0]            off_r;
  logic                  store_r;
  logic                  fault_r;
  logic                  holdoff_r;
  logic                  blocked_r;
  logic                  sample_r;
  logic [31:0]           rdata_r;
  logic                  complete_r;
  logic                  fault_out_r;
  logic [RAM_AWIDTH-1:0] ram_addr_r;
  logic [3:0]            ram_be_r;
  logic [31:0]           ram_wdata_r;
  logic                  ram_we_r;

  logic                  req_s;
  logic                  start_s;
  logic [1:0]            off_s;
  logic                  fault_s;
  logic [3:0]            be_s;
  logic [31:0]           lane_s;
  logic [31:0]           ld_ext_s;
  logic                  unused_addr_s;

  assign req_s         = mem_read | mem_write;
  assign start_s       = (state_r == ST_IDLE) && req_s && !holdoff_r && !blocked_r;
  assign unused_addr_s = ^addr[31:RAM_AWIDTH+2];

  // Natural-alignment offset and, when checking is built in, misalignment fault.
  always_comb begin
    off_s   = addr[1:0];
    fault_s = 1'b0;
    case (access_size(funct3))
      SZ_BYTE: off_s = addr[1:0];
      SZ_HALF: off_s = {addr[1], 1'b0};
      SZ_WORD: off_s = 2'b00;
      default: off_s = 2'b00;
    endcase
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    case (access_size(funct3))
      SZ_HALF: fault_s = addr[0];
      SZ_WORD: fault_s = (addr[1:0] != 2'b00);
      default: fault_s = 1'b0;
    endcase
`else
    fault_s = 1'b0;
`endif
  end

  mem_lane_align u_align (
    .st_funct3 (funct3),
    .st_off    (off_s),
    .st_wdata  (wdata),
    .ld_funct3 (funct3_r),
    .ld_off    (off_r),
    .ld_raw    (ram_rdata),
    .st_be     (be_s),
    .st_lane   (lane_s),
    .ld_ext    (ld_ext_s)
  );

  // Next-state logic; faulted accesses bypass the wait phase.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) state_s = ST_ACCESS;
        else         state_s = ST_IDLE;
      end
      ST_ACCESS: begin
        if (fault_r || (WAIT_STATES == 0)) state_s = ST_DONE;
        else                               state_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_r >= WS) state_s = ST_DONE;
        else             state_s = ST_WAIT;
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State, capture registers and registered RAM/handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      funct3_r    <= 3'b000;
      off_r       <= 2'b00;
      store_r     <= 1'b0;
      fault_r     <= 1'b0;
      holdoff_r   <= 1'b0;
      blocked_r   <= 1'b0;
      sample_r    <= 1'b0;
      rdata_r     <= 32'h0000_0000;
      complete_r  <= 1'b0;
      fault_out_r <= 1'b0;
      ram_addr_r  <= '0;
      ram_be_r    <= 4'b0000;
      ram_wdata_r <= 32'h0000_0000;
      ram_we_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      holdoff_r   <= (state_r == ST_DONE);
      complete_r  <= (state_s == ST_DONE);
      fault_out_r <= (state_s == ST_DONE) && fault_r;
      sample_r    <= (state_r == ST_ACCESS) && !store_r && !fault_r;

      // A request still held after completion must drop before it can start again.
      if (!req_s)                    blocked_r <= 1'b0;
      else if (state_r == ST_DONE)   blocked_r <= 1'b1;
      else                           blocked_r <= blocked_r;

      if (state_s == ST_WAIT) cnt_r <= (state_r == ST_WAIT) ? cnt_r + 4'd1 : 4'd1;
      else                    cnt_r <= 4'd0;

      if (sample_r) rdata_r <= ld_ext_s;
      else          rdata_r <= rdata_r;

      if (start_s) begin
        funct3_r    <= funct3;
        off_r       <= off_s;
        store_r     <= mem_write;
        fault_r     <= fault_s;
        ram_addr_r  <= addr[RAM_AWIDTH+1:2];
        ram_be_r    <= fault_s ? 4'b0000 : be_s;
        ram_wdata_r <= lane_s;
        ram_we_r    <= mem_write && !fault_s;
      end else if (state_r == ST_ACCESS) begin
        ram_be_r    <= 4'b0000;
        ram_we_r    <= 1'b0;
      end else begin
        ram_be_r    <= ram_be_r;
        ram_we_r    <= ram_we_r;
      end
    end
  end

  // With no wait states the RAM data arrives in DONE itself, so forward it.
  assign rdata        = ((WAIT_STATES == 0) && sample_r && (state_r == ST_DONE)) ? ld_ext_s : rdata_r;
  assign mem_complete = complete_r;
  assign mem_fault    = fault_out_r;
  assign ram_addr     = ram_addr_r;
  assign ram_be       = ram_be_r;
  assign ram_wdata    = ram_wdata_r;
  assign ram_we       = ram_we_r;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder with a behavioural synchronous-read RAM.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        mem_complete;
  logic        mem_fault;
  logic [11:0] ram_addr;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic        ram_we;
  logic [31:0] ram_rdata;

  logic [31:0] mem [0:4095];

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
  } exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad = 0;
  int we_cnt = 0;
  int acc_cnt = 0;
  int cmp_cnt = 0;
  logic [3:0]  we_be;
  logic [31:0] we_wdata;
  logic [11:0] we_addr;
  logic [31:0] last_load = 32'h0;

  mem_responder #(.WAIT_STATES(1), .RAM_AWIDTH(12)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .funct3       (funct3),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .mem_complete (mem_complete),
    .mem_fault    (mem_fault),
    .ram_addr     (ram_addr),
    .ram_be       (ram_be),
    .ram_wdata    (ram_wdata),
    .ram_we       (ram_we),
    .ram_rdata    (ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM: byte-enabled write, registered read.
  always @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
    ram_rdata <= mem[ram_addr];
  end

  // Bus monitor.
  always @(negedge clk) begin
    if (ram_we) begin
      we_cnt   <= we_cnt + 1;
      we_be    <= ram_be;
      we_wdata <= ram_wdata;
      we_addr  <= ram_addr;
    end
    if (ram_be != 4'b0000) acc_cnt <= acc_cnt + 1;
    if (mem_complete) cmp_cnt <= cmp_cnt + 1;
  end

  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input int hold_extra,
                       output int lat, output logic [31:0] rd_obs, output logic flt_obs);
    logic got;
    got = 1'b0;
    lat = 0;
    rd_obs = 32'h0;
    flt_obs = 1'b0;
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_complete) begin
        got = 1'b1;
        rd_obs = rdata;
        flt_obs = mem_fault;
        break;
      end
      lat++;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL complete_timeout: got none want mem_complete addr=%h", a);
    end
    repeat (hold_extra) @(posedge clk);
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (mem_complete !== 1'b0) begin bad++; $display("FAIL rst_complete: got %b want 0", mem_complete); end
    total++; if (mem_fault !== 1'b0)    begin bad++; $display("FAIL rst_fault: got %b want 0", mem_fault); end
    total++; if (ram_we !== 1'b0)       begin bad++; $display("FAIL rst_we: got %b want 0", ram_we); end
    total++; if (ram_be !== 4'h0)       begin bad++; $display("FAIL rst_be: got %h want 0", ram_be); end
    total++; if (rdata !== 32'h0)       begin bad++; $display("FAIL rst_rdata: got %h want 0", rdata); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_store_word();
    int lat; logic [31:0] r; logic f; int we0; exp_t e;
    we0 = we_cnt;
    e.rdata = last_load; e.fault = 1'b0; exp_q.push_back(e);
    issue(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, lat, r, f);
    e = exp_q.pop_front();
    total++; if (lat !== 3)          begin bad++; $display("FAIL sw_latency: got %0d want 3", lat); end
    total++; if (we_cnt - we0 !== 1) begin bad++; $display("FAIL sw_we_cycles: got %0d want 1", we_cnt - we0); end
    total++; if (we_be !== 4'hF)     begin bad++; $display("FAIL sw_be: got %h want f", we_be); end
    total++; if (we_addr !== 12'h040) begin bad++; $display("FAIL sw_addr: got %h want 040", we_addr); end
    total++; if (we_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_wdata: got %h want deadbeef", we_wdata); end
    total++; if (r !== e.rdata || f !== e.fault) begin bad++; $display("FAIL sw_rdata_hold: got %h/%b want %h/%b", r, f, e.rdata, e.fault); end
  endtask

  task automatic test_load_ext();
    int lat; logic [31:0] r; logic f; exp_t e;
    logic [2:0]  f3s [7];
    logic [31:0] as  [7];
    logic [31:0] es  [7];
    f3s = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b101, 3'b001, 3'b010};
    as  = '{32'h100, 32'h100, 32'h101, 32'h102, 32'h100, 32'h100, 32'h100};
    es  = '{32'hDEADBEEF, 32'hFFFFFFF0, 32'h00000080, 32'h00000000, 32'h000080F0, 32'hFFFF80F0, 32'h000080F0};
    for (int i = 0; i < 7; i++) begin
      if (i == 1) issue(1'b0, 1'b1, 3'b010, 32'h100, 32'h000080F0, 0, lat, r, f);
      e.rdata = es[i]; e.fault = 1'b0; exp_q.push_back(e);
      issue(1'b1, 1'b0, f3s[i], as[i], 32'h0, 0, lat, r, f);
      e = exp_q.pop_front();
      total++;
      if (r !== e.rdata || f !== e.fault) begin
        bad++; $display("FAIL load_%0d: got %h/%b want %h/%b", i, r, f, e.rdata, e.fault);
      end
      last_load = e.rdata;
    end
  endtask

  task automatic test_store_byte_half();
    int lat; logic [31:0] r; logic f; exp_t e;
    issue(1'b0, 1'b1, 3'b000, 32'h103, 32'h000000AA, 0, lat, r, f);
    total++; if (we_be !== 4'b1000) begin bad++; $display("FAIL sb_be: got %b want 1000", we_be); end
    total++; if (we_wdata[31:24] !== 8'hAA) begin bad++; $display("FAIL sb_lane: got %h want aa", we_wdata[31:24]); end
    total++; if (r !== last_load) begin bad++; $display("FAIL sb_rdata_hold: got %h want %h", r, last_load); end
    issue(1'b0, 1'b1, 3'b001, 32'h102, 32'h00001234, 0, lat, r, f);
    total++; if (we_be !== 4'b1100) begin bad++; $display("FAIL sh_be: got %b want 1100", we_be); end
    e.rdata = 32'h123480F0; e.fault = 1'b0; exp_q.push_back(e);
    issue(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, lat, r, f);
    e = exp_q.pop_front();
    total++; if (r !== e.rdata) begin bad++; $display("FAIL sb_sh_readback: got %h want %h", r, e.rdata); end
    last_load = e.rdata;
  endtask

  task automatic test_both_and_unused();
    int lat; logic [31:0] r; logic f; int we0; exp_t e;
    we0 = we_cnt;
    issue(1'b1, 1'b1, 3'b010, 32'h104, 32'h55667788, 0, lat, r, f);
    total++; if (we_cnt - we0 !== 1) begin bad++; $display("FAIL both_we: got %0d want 1", we_cnt - we0); end
    total++; if (r !== last_load) begin bad++; $display("FAIL both_rdata: got %h want %h", r, last_load); end
    issue(1'b0, 1'b1, 3'b011, 32'h108, 32'h0BADF00D, 0, lat, r, f);
    total++; if (we_be !== 4'hF) begin bad++; $display("FAIL f3_011_be: got %h want f", we_be); end
    e.rdata = 32'h55667788; e.fault = 1'b0; exp_q.push_back(e);
    e.rdata = 32'h0BADF00D; e.fault = 1'b0; exp_q.push_back(e);
    issue(1'b1, 1'b0, 3'b110, 32'h104, 32'h0, 0, lat, r, f);
    e = exp_q.pop_front();
    total++; if (r !== e.rdata) begin bad++; $display("FAIL f3_110_load: got %h want %h", r, e.rdata); end
    issue(1'b1, 1'b0, 3'b111, 32'h108, 32'h0, 0, lat, r, f);
    e = exp_q.pop_front();
    total++; if (r !== e.rdata) begin bad++; $display("FAIL f3_111_load: got %h want %h", r, e.rdata); end
    last_load = e.rdata;
  endtask

  task automatic test_holdoff();
    int lat; logic [31:0] r; logic f; int c0; int a0;
    c0 = cmp_cnt; a0 = acc_cnt;
    issue(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 4, lat, r, f);
    total++; if (cmp_cnt - c0 !== 1) begin bad++; $display("FAIL holdoff_completes: got %0d want 1", cmp_cnt - c0); end
    total++; if (acc_cnt - a0 !== 1) begin bad++; $display("FAIL holdoff_accesses: got %0d want 1", acc_cnt - a0); end
    total++; if (r !== 32'h123480F0) begin bad++; $display("FAIL holdoff_rdata: got %h want 123480f0", r); end
    last_load = 32'h123480F0;
  endtask

  task automatic test_misalign();
    int lat; logic [31:0] r; logic f; int we0;
    we0 = we_cnt;
    issue(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 0, lat, r, f);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    total++; if (f !== 1'b1) begin bad++; $display("FAIL lw_mis_fault: got %b want 1", f); end
    total++; if (r !== last_load) begin bad++; $display("FAIL lw_mis_rdata: got %h want %h", r, last_load); end
    issue(1'b0, 1'b1, 3'b001, 32'h105, 32'h0000BEEF, 0, lat, r, f);
    total++; if (f !== 1'b1) begin bad++; $display("FAIL sh_mis_fault: got %b want 1", f); end
    total++; if (we_cnt - we0 !== 0) begin bad++; $display("FAIL mis_we: got %0d want 0", we_cnt - we0); end
`else
    total++; if (f !== 1'b0) begin bad++; $display("FAIL lw_mis_fault: got %b want 0", f); end
    total++; if (r !== 32'h123480F0) begin bad++; $display("FAIL lw_mis_rdata: got %h want 123480f0", r); end
    last_load = 32'h123480F0;
    issue(1'b0, 1'b1, 3'b001, 32'h105, 32'h0000BEEF, 0, lat, r, f);
    total++; if (we_be !== 4'b0011) begin bad++; $display("FAIL sh_mis_be: got %b want 0011", we_be); end
    total++; if (we_cnt - we0 !== 1) begin bad++; $display("FAIL mis_we: got %0d want 1", we_cnt - we0); end
`endif
  endtask

  task automatic test_reset_mid();
    int we0; int c0;
    we0 = we_cnt; c0 = cmp_cnt;
    @(posedge clk); #1;
    mem_write = 1'b1; funct3 = 3'b010; addr = 32'h10C; wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; mem_write = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++; if (mem_complete !== 1'b0) begin bad++; $display("FAIL midrst_complete: got %b want 0", mem_complete); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL midrst_rdata: got %h want 0", rdata); end
    repeat (5) @(posedge clk);
    #1;
    total++; if (cmp_cnt - c0 !== 0) begin bad++; $display("FAIL midrst_no_complete: got %0d want 0", cmp_cnt - c0); end
    total++; if (we_cnt - we0 !== 1) begin bad++; $display("FAIL midrst_we: got %0d want 1", we_cnt - we0); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store_word();
    test_load_ext();
    test_store_byte_half();
    test_both_and_unused();
    test_holdoff();
    test_misalign();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
